axis_channel_split: RTL and testbench

AXIS_CHANNEL_SPLIT -- requirements
Module: axis_channel_split

---
 rtl/axis_channel_split.sv | 119 +++++++++++
 tb/tb_axis_channel_split.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_channel_split.sv
// Splits one packed multi-channel AXI-Stream into NCH independent streams.
// Each output channel has its own 2-entry FIFO whose head drives the outputs from flops.
module axis_channel_split #(
  parameter int NCH            = 2,
  parameter int ADC_DATA_WIDTH = 16,
  parameter int OUT_DATA_WIDTH = 32,
  parameter int SIGNED         = 1,
  parameter int DROP_MODE      = 0
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [NCH*ADC_DATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                          S_AXIS_tvalid,
  output logic                          S_AXIS_tready,
  input  logic [NCH-1:0]                ch_enable,
  input  logic                          ovf_clear,
  output logic [NCH*OUT_DATA_WIDTH-1:0] M_AXIS_tdata,
  output logic [NCH-1:0]                M_AXIS_tvalid,
  input  logic [NCH-1:0]                M_AXIS_tready,
  output logic [NCH-1:0]                overflow
);

  logic [NCH-1:0] full;
  logic           in_xfer;

  assign in_xfer = S_AXIS_tvalid & S_AXIS_tready;

  // Ready only looks at the registered full flags, never at downstream ready.
  generate
    if (DROP_MODE != 0) begin : g_ready_drop
      assign S_AXIS_tready = aresetn;
    end else begin : g_ready_block
      assign S_AXIS_tready = aresetn & ~(|(ch_enable & full));
    end
  endgenerate

  generate
    for (genvar k = 0; k < NCH; k++) begin : g_ch
      logic [ADC_DATA_WIDTH-1:0] raw;
      logic [OUT_DATA_WIDTH-1:0] ext;
      logic [OUT_DATA_WIDTH-1:0] head_q;
      logic [OUT_DATA_WIDTH-1:0] tail_q;
      logic [1:0]                cnt_q;
      logic                      valid_q;
      logic                      ovf_q;
      logic                      push;
      logic                      pop;
      logic                      drop;

      assign raw = S_AXIS_tdata[k*ADC_DATA_WIDTH +: ADC_DATA_WIDTH];

      if (OUT_DATA_WIDTH == ADC_DATA_WIDTH) begin : g_ext_none
        assign ext = raw;
      end else if (SIGNED != 0) begin : g_ext_sign
        assign ext = {{(OUT_DATA_WIDTH-ADC_DATA_WIDTH){raw[ADC_DATA_WIDTH-1]}}, raw};
      end else begin : g_ext_zero
        assign ext = {{(OUT_DATA_WIDTH-ADC_DATA_WIDTH){1'b0}}, raw};
      end

      assign push = in_xfer & ch_enable[k] & ~cnt_q[1];
      assign drop = in_xfer & ch_enable[k] &  cnt_q[1];
      assign pop  = valid_q & M_AXIS_tready[k];

      // valid_q mirrors (cnt_q != 0) so tvalid comes straight from a flop.
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          head_q  <= '0;
          tail_q  <= '0;
          cnt_q   <= 2'd0;
          valid_q <= 1'b0;
        end else begin
          case (cnt_q)
            2'd0: begin
              if (push) begin
                head_q  <= ext;
                cnt_q   <= 2'd1;
                valid_q <= 1'b1;
              end
            end
            2'd1: begin
              if (push && pop) begin
                head_q <= ext;
              end else if (push) begin
                tail_q <= ext;
                cnt_q  <= 2'd2;
              end else if (pop) begin
                cnt_q   <= 2'd0;
                valid_q <= 1'b0;
              end
            end
            default: begin
              if (pop) begin
                head_q <= tail_q;
                cnt_q  <= 2'd1;
              end
            end
          endcase
        end
      end

      // A drop in the same cycle as a clear must leave the flag set.
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          ovf_q <= 1'b0;
        end else if ((DROP_MODE != 0) && drop) begin
          ovf_q <= 1'b1;
        end else if (ovf_clear) begin
          ovf_q <= 1'b0;
        end
      end

      assign M_AXIS_tdata[k*OUT_DATA_WIDTH +: OUT_DATA_WIDTH] = head_q;
      assign M_AXIS_tvalid[k] = valid_q;
      assign overflow[k]      = ovf_q;
      assign full[k]          = cnt_q[1];
    end
  endgenerate

endmodule

// File: tb/tb_axis_channel_split.sv
// Directed bench for axis_channel_split: signed, unsigned and drop-mode instances.
module tb_axis_channel_split;

  logic        aclk;
  logic        aresetn;
  logic [27:0] s_tdata;
  logic        tvalid_a;
  logic        tvalid_d;
  logic [1:0]  ch_enable;
  logic        ovf_clear;
  logic [1:0]  m_tready_a;
  logic [1:0]  m_tready_d;

  logic        a_tready, u_tready, d_tready;
  logic [63:0] a_tdata, u_tdata, d_tdata;
  logic [1:0]  a_tvalid, u_tvalid, d_tvalid;
  logic [1:0]  a_ovf, u_ovf, d_ovf;

  int total = 0;
  int bad   = 0;

  axis_channel_split #(.NCH(2), .ADC_DATA_WIDTH(14), .OUT_DATA_WIDTH(32), .SIGNED(1), .DROP_MODE(0)) u_sgn (
    .aclk(aclk), .aresetn(aresetn), .S_AXIS_tdata(s_tdata), .S_AXIS_tvalid(tvalid_a),
    .S_AXIS_tready(a_tready), .ch_enable(ch_enable), .ovf_clear(ovf_clear),
    .M_AXIS_tdata(a_tdata), .M_AXIS_tvalid(a_tvalid), .M_AXIS_tready(m_tready_a), .overflow(a_ovf));

  axis_channel_split #(.NCH(2), .ADC_DATA_WIDTH(14), .OUT_DATA_WIDTH(32), .SIGNED(0), .DROP_MODE(0)) u_uns (
    .aclk(aclk), .aresetn(aresetn), .S_AXIS_tdata(s_tdata), .S_AXIS_tvalid(tvalid_a),
    .S_AXIS_tready(u_tready), .ch_enable(ch_enable), .ovf_clear(ovf_clear),
    .M_AXIS_tdata(u_tdata), .M_AXIS_tvalid(u_tvalid), .M_AXIS_tready(m_tready_a), .overflow(u_ovf));

  axis_channel_split #(.NCH(2), .ADC_DATA_WIDTH(14), .OUT_DATA_WIDTH(32), .SIGNED(1), .DROP_MODE(1)) u_drp (
    .aclk(aclk), .aresetn(aresetn), .S_AXIS_tdata(s_tdata), .S_AXIS_tvalid(tvalid_d),
    .S_AXIS_tready(d_tready), .ch_enable(ch_enable), .ovf_clear(ovf_clear),
    .M_AXIS_tdata(d_tdata), .M_AXIS_tvalid(d_tvalid), .M_AXIS_tready(m_tready_d), .overflow(d_ovf));

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic applyStimulus(input logic [13:0] c0, input logic [13:0] c1,
                               input logic va, input logic vd);
    s_tdata  = {c1, c0};
    tvalid_a = va;
    tvalid_d = vd;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    aresetn    = 1'b0;
    s_tdata    = '0;
    tvalid_a   = 1'b0;
    tvalid_d   = 1'b0;
    ch_enable  = 2'b11;
    ovf_clear  = 1'b0;
    m_tready_a = 2'b00;
    m_tready_d = 2'b00;

    // Reset state
    #2;
    checkOutput("rst_tvalid", 64'(a_tvalid), 64'h0);
    checkOutput("rst_tdata", a_tdata, 64'h0);
    checkOutput("rst_tready", 64'(a_tready), 64'h0);
    checkOutput("rst_drop_tready", 64'(d_tready), 64'h0);
    checkOutput("rst_overflow", 64'(d_ovf), 64'h0);
    tick();
    tick();
    aresetn = 1'b1;
    #1;
    checkOutput("rel_tready", 64'(a_tready), 64'h1);
    checkOutput("rel_drop_tready", 64'(d_tready), 64'h1);

    // Sign and zero extension, 1-cycle latency
    m_tready_a = 2'b11;
    applyStimulus(14'h1FFF, 14'h2000, 1'b1, 1'b0);
    tick();
    applyStimulus(14'h0, 14'h0, 1'b0, 1'b0);
    checkOutput("ext_valid", 64'(a_tvalid), 64'h3);
    checkOutput("sext_ch0", 64'(a_tdata[31:0]), 64'h00001FFF);
    checkOutput("sext_ch1", 64'(a_tdata[63:32]), 64'hFFFFE000);
    checkOutput("zext_ch0", 64'(u_tdata[31:0]), 64'h00001FFF);
    checkOutput("zext_ch1", 64'(u_tdata[63:32]), 64'h00002000);
    tick();
    checkOutput("ext_drain", 64'(a_tvalid), 64'h0);

    // Blocking backpressure with ch1 stalled
    m_tready_a = 2'b01;
    applyStimulus(14'h11, 14'h21, 1'b1, 1'b0);
    checkOutput("bp_tready0", 64'(a_tready), 64'h1);
    tick();
    applyStimulus(14'h12, 14'h22, 1'b1, 1'b0);
    checkOutput("bp_ch0_s1", 64'(a_tdata[31:0]), 64'h11);
    tick();
    applyStimulus(14'h13, 14'h23, 1'b1, 1'b0);
    checkOutput("bp_tready_fall", 64'(a_tready), 64'h0);
    checkOutput("bp_ch0_s2", 64'(a_tdata[31:0]), 64'h12);
    checkOutput("bp_ch1_head", 64'(a_tdata[63:32]), 64'h21);
    checkOutput("bp_valid_full", 64'(a_tvalid), 64'h3);
    tick();
    checkOutput("bp_stall_valid", 64'(a_tvalid), 64'h2);
    checkOutput("bp_stall_tready", 64'(a_tready), 64'h0);
    m_tready_a = 2'b11;
    #1;
    checkOutput("bp_no_comb_path", 64'(a_tready), 64'h0);
    tick();
    checkOutput("bp_ch1_s2", 64'(a_tdata[63:32]), 64'h22);
    checkOutput("bp_reopen", 64'(a_tready), 64'h1);
    tick();
    applyStimulus(14'h0, 14'h0, 1'b0, 1'b0);
    checkOutput("bp_ch0_s3", 64'(a_tdata[31:0]), 64'h13);
    checkOutput("bp_ch1_s3", 64'(a_tdata[63:32]), 64'h23);
    checkOutput("bp_valid_s3", 64'(a_tvalid), 64'h3);
    tick();
    checkOutput("bp_empty", 64'(a_tvalid), 64'h0);
    checkOutput("bp_no_overflow", 64'(a_ovf), 64'h0);

    // Disabled full channel stops contributing to backpressure
    m_tready_a = 2'b00;
    applyStimulus(14'h31, 14'h41, 1'b1, 1'b0);
    tick();
    applyStimulus(14'h32, 14'h42, 1'b1, 1'b0);
    tick();
    checkOutput("en_both_full", 64'(a_tready), 64'h0);
    ch_enable  = 2'b01;
    m_tready_a = 2'b01;
    applyStimulus(14'h33, 14'h43, 1'b1, 1'b0);
    checkOutput("en_ch0_still_full", 64'(a_tready), 64'h0);
    tick();
    checkOutput("en_tready_open", 64'(a_tready), 64'h1);
    checkOutput("en_ch0_h32", 64'(a_tdata[31:0]), 64'h32);
    tick();
    applyStimulus(14'h34, 14'h44, 1'b1, 1'b0);
    checkOutput("en_ch0_h33", 64'(a_tdata[31:0]), 64'h33);
    checkOutput("en_tready_h33", 64'(a_tready), 64'h1);
    checkOutput("en_ch1_held", 64'(a_tdata[63:32]), 64'h41);
    checkOutput("en_valid", 64'(a_tvalid), 64'h3);
    tick();
    applyStimulus(14'h0, 14'h0, 1'b0, 1'b0);
    checkOutput("en_ch0_h34", 64'(a_tdata[31:0]), 64'h34);
    checkOutput("en_tready_h34", 64'(a_tready), 64'h1);
    tick();
    checkOutput("en_ch0_drained", 64'(a_tvalid), 64'h2);

    // Disabled channel still drains its buffered samples
    m_tready_a = 2'b10;
    tick();
    checkOutput("dis_drain_h42", 64'(a_tdata[63:32]), 64'h42);
    checkOutput("dis_drain_valid", 64'(a_tvalid), 64'h2);
    tick();
    checkOutput("dis_drain_empty", 64'(a_tvalid), 64'h0);
    ch_enable  = 2'b11;
    m_tready_a = 2'b00;

    // Asynchronous reset with both FIFOs full
    applyStimulus(14'h51, 14'h61, 1'b1, 1'b0);
    tick();
    applyStimulus(14'h52, 14'h62, 1'b1, 1'b0);
    tick();
    applyStimulus(14'h0, 14'h0, 1'b0, 1'b0);
    checkOutput("ar_full_valid", 64'(a_tvalid), 64'h3);
    #2;
    aresetn = 1'b0;
    #1;
    checkOutput("ar_valid_now", 64'(a_tvalid), 64'h0);
    checkOutput("ar_tdata_now", a_tdata, 64'h0);
    checkOutput("ar_tready_now", 64'(a_tready), 64'h0);
    tick();
    aresetn = 1'b1;
    #1;
    checkOutput("ar_rel_valid", 64'(a_tvalid), 64'h0);
    checkOutput("ar_rel_tready", 64'(a_tready), 64'h1);
    m_tready_a = 2'b11;
    applyStimulus(14'h71, 14'h81, 1'b1, 1'b0);
    tick();
    applyStimulus(14'h0, 14'h0, 1'b0, 1'b0);
    checkOutput("ar_fresh_ch0", 64'(a_tdata[31:0]), 64'h71);
    checkOutput("ar_fresh_ch1", 64'(a_tdata[63:32]), 64'h81);
    tick();
    checkOutput("ar_fresh_empty", 64'(a_tvalid), 64'h0);

    // Drop mode: ch1 held not-ready for inputs 1..5
    m_tready_d = 2'b01;
    for (int n = 1; n <= 5; n++) begin
      applyStimulus(14'(n), 14'(n), 1'b0, 1'b1);
      checkOutput("drop_tready", 64'(d_tready), 64'h1);
      tick();
      checkOutput("drop_ch0_seq", 64'(d_tdata[31:0]), 64'(n));
      checkOutput("drop_ovf_seq", 64'(d_ovf), (n >= 3) ? 64'h2 : 64'h0);
    end
    applyStimulus(14'h0, 14'h0, 1'b0, 1'b0);
    checkOutput("drop_ch1_h1", 64'(d_tdata[63:32]), 64'h1);
    checkOutput("drop_valid", 64'(d_tvalid), 64'h3);
    m_tready_d = 2'b11;
    tick();
    checkOutput("drop_ch1_h2", 64'(d_tdata[63:32]), 64'h2);
    checkOutput("drop_valid_h2", 64'(d_tvalid), 64'h2);
    tick();
    checkOutput("drop_empty", 64'(d_tvalid), 64'h0);
    checkOutput("drop_ovf_sticky", 64'(d_ovf), 64'h2);
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    checkOutput("drop_ovf_clear", 64'(d_ovf), 64'h0);

    // Drop in the same cycle as clear keeps the flag set
    m_tready_d = 2'b00;
    applyStimulus(14'h91, 14'h92, 1'b0, 1'b1);
    tick();
    tick();
    applyStimulus(14'h93, 14'h94, 1'b0, 1'b1);
    ovf_clear = 1'b1;
    checkOutput("drop_full_tready", 64'(d_tready), 64'h1);
    tick();
    ovf_clear = 1'b0;
    applyStimulus(14'h0, 14'h0, 1'b0, 1'b0);
    checkOutput("drop_wins_clear", 64'(d_ovf), 64'h3);
    checkOutput("drop_head_kept", 64'(d_tdata[31:0]), 64'h91);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
